fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer for the 256x16 synchronous-read instruction ROM
//  (ROM data appears on rom_instr one clk edge after rom_addr). Owns the PC,
//  hides the 1-cycle ROM latency, and delivers instructions to decode over a
//  valid/ready handshake. Supports redirects (jump/branch), start and halt.
// PARAMETERS
//  ADDR_WIDTH   8    ROM address / PC width
//  INSTR_WIDTH  16   instruction width
//  RESET_PC     0    PC loaded on reset and on start from IDLE
// PORTS
//  clk            in   1           system clock, all state on posedge
//  rst_n          in   1           asynchronous active-low reset
//  start          in   1           pulse: IDLE/HALTED -> RUN
//  halt           in   1           pulse: RUN -> HALTED
//  redirect_valid in   1           load new PC (flushes pipe)
//  redirect_pc    in   ADDR_WIDTH  redirect target
//  rom_addr       out  ADDR_WIDTH  address to ROM (combinational)
//  rom_instr      in   INSTR_WIDTH ROM read data
//  out_valid      out  1           out_instr/out_pc hold an instruction
//  out_ready      in   1           decode accepts this cycle
//  out_instr      out  INSTR_WIDTH fetched instruction (registered)
//  out_pc         out  ADDR_WIDTH  address of out_instr (registered)
//  running        out  1           state == RUN
// BEHAVIOUR
//  - Reset: state=IDLE, fetch_pc=RESET_PC, inflight=0, out_valid=0,
//    out_instr=0, out_pc=0, running=0; rom_addr=RESET_PC.
//  - States: IDLE -start-> RUN; RUN -halt-> HALTED; HALTED -start-> RUN
//    (resumes at fetch_pc). redirect_valid in IDLE/HALTED loads fetch_pc only.
//  - adv = !out_valid | out_ready. inflight/inflight_pc track the read issued
//    last cycle whose data is on rom_instr now.
//  - RUN, adv: if inflight, out_* <= {rom_instr, inflight_pc}, out_valid<=1;
//    else out_valid<=0. rom_addr=fetch_pc; inflight<=1; inflight_pc<=fetch_pc;
//    fetch_pc<=fetch_pc+1.
//  - RUN, !adv (stall): out_* held; rom_addr=inflight_pc (replay read so data
//    stays valid); fetch_pc, inflight, inflight_pc unchanged.
//  - Steady-state throughput 1 instr/cycle; start->first out_valid = 2 edges.
//  - redirect_valid in RUN (priority over adv/halt): out_valid<=0 regardless of
//    out_ready (transfer that cycle is void); rom_addr=redirect_pc same cycle;
//    inflight<=1; inflight_pc<=redirect_pc; fetch_pc<=redirect_pc+1.
//    First redirected instr valid 2 edges after redirect.
//  - halt in RUN: no new read issued; in-flight data captured if adv that cycle,
//    else discarded and fetch_pc<=inflight_pc; inflight<=0; out_* kept until
//    accepted. start+halt same cycle: halt wins. start in RUN ignored.
//  - PC arithmetic modulo 2^ADDR_WIDTH; fetch_pc 255 -> 0 (see CONFIGURATION).
// CONFIGURATION
//  FETCH_WRAP_HALT_EN defined: issuing the read at the max address moves state
//    to HALTED after that read (data still delivered); fetch_pc becomes 0;
//    extra output wrap_halt (1 bit, reset 0, sticky until next start).
//  Undefined: PC wraps 255 -> 0 silently, fetch continues; no wrap_halt port.
// TESTING
//  1 reset, start, out_ready=1, ROM[i]=i -> out_pc 0,1,2.. one per cycle, first
//    out_valid 2 edges after start, out_instr==ROM[out_pc].
//  2 out_ready low 3 cycles at pc=5 -> out_pc/out_instr held at 5; resume gives
//    6,7.. with no gap, duplicate or skip.
//  3 redirect_valid pc=0x40 while out_pc=3 valid -> out_valid 0 next cycle,
//    then out_pc 0x40,0x41; no 4/5 emitted.
//  4 halt at pc=10 under stall -> running=0, pending instr delivered once;
//    start -> fetch resumes at next unfetched address, sequence contiguous.
//  5 redirect to 0xFE, run -> 0xFE,0xFF,0x00 (macro off); macro on: 0xFE,0xFF
//    then HALTED, wrap_halt=1.
//  6 rst_n low mid-stream -> all outputs to reset values immediately (async).

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Fetch sequencer bus: synchronous ROM read port plus the valid/ready
// instruction channel towards decode.
interface fetch_ctrl_if #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0]  rom_addr;
  logic [INSTR_WIDTH-1:0] rom_instr;
  logic                   out_valid;
  logic                   out_ready;
  logic [INSTR_WIDTH-1:0] out_instr;
  logic [ADDR_WIDTH-1:0]  out_pc;

  modport master (
    output rom_addr, out_valid, out_instr, out_pc,
    input  rom_instr, out_ready
  );

  modport slave (
    input  rom_addr, out_valid, out_instr, out_pc,
    output rom_instr, out_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, hides the 1-cycle ROM latency and
// feeds decode over valid/ready. Optional FETCH_WRAP_HALT_EN halts on PC wrap.
module fetch_ctrl #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 16,
  parameter int RESET_PC    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  halt,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  fetch_ctrl_if.master          bus,
  output logic                  running
`ifdef FETCH_WRAP_HALT_EN
  ,
  output logic                  wrap_halt
`endif
);

  localparam logic [ADDR_WIDTH-1:0] PC_RST = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);
`ifdef FETCH_WRAP_HALT_EN
  localparam logic [ADDR_WIDTH-1:0] PC_MAX = '1;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic                   inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0]  inflight_pc_q, inflight_pc_d;
  logic                   out_valid_q, out_valid_d;
  logic [INSTR_WIDTH-1:0] out_instr_q, out_instr_d;
  logic [ADDR_WIDTH-1:0]  out_pc_q, out_pc_d;
`ifdef FETCH_WRAP_HALT_EN
  logic                   wrap_halt_q, wrap_halt_d;
`endif

  logic                   adv;
  logic                   capture;
  logic                   issue;
  logic [ADDR_WIDTH-1:0]  issue_pc;
  logic [ADDR_WIDTH-1:0]  rom_addr_c;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    out_valid_d   = out_valid_q;
    out_instr_d   = out_instr_q;
    out_pc_d      = out_pc_q;
`ifdef FETCH_WRAP_HALT_EN
    wrap_halt_d   = wrap_halt_q;
`endif
    rom_addr_c    = fetch_pc_q;
    capture       = 1'b0;
    issue         = 1'b0;
    issue_pc      = fetch_pc_q;
    adv           = !out_valid_q || bus.out_ready;

    case (state_q)
      S_RUN: begin
        if (redirect_valid) begin
          // Flush: whatever sits on the output this cycle is dropped.
          out_valid_d = 1'b0;
          issue       = 1'b1;
          issue_pc    = redirect_pc;
        end else begin
          capture = adv;
          if (halt) begin
            state_d    = S_HALTED;
            inflight_d = 1'b0;
            if (!adv && inflight_q) fetch_pc_d = inflight_pc_q;
          end else if (adv) begin
            issue = 1'b1;
          end else begin
            rom_addr_c = inflight_pc_q;
          end
        end
      end
      default: begin
        // A read can still be in flight here only after a wrap-halt.
        capture = adv;
        if (adv) begin
          inflight_d = 1'b0;
        end else if (inflight_q) begin
          rom_addr_c = inflight_pc_q;
        end
        if (start && !halt) begin
          state_d = S_RUN;
`ifdef FETCH_WRAP_HALT_EN
          wrap_halt_d = 1'b0;
`endif
          if (!inflight_q) begin
            issue    = 1'b1;
            issue_pc = (state_q == S_IDLE) ? PC_RST : fetch_pc_q;
          end
        end else if (redirect_valid) begin
          fetch_pc_d = redirect_pc;
        end
      end
    endcase

    if (capture) begin
      out_valid_d = inflight_q;
      if (inflight_q) begin
        out_instr_d = bus.rom_instr;
        out_pc_d    = inflight_pc_q;
      end
    end

    if (issue) begin
      rom_addr_c    = issue_pc;
      inflight_d    = 1'b1;
      inflight_pc_d = issue_pc;
      fetch_pc_d    = issue_pc + PC_ONE;
`ifdef FETCH_WRAP_HALT_EN
      if (issue_pc == PC_MAX) begin
        state_d     = S_HALTED;
        wrap_halt_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      fetch_pc_q    <= PC_RST;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      out_valid_q   <= 1'b0;
      out_instr_q   <= '0;
      out_pc_q      <= '0;
`ifdef FETCH_WRAP_HALT_EN
      wrap_halt_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_pc_q      <= out_pc_d;
`ifdef FETCH_WRAP_HALT_EN
      wrap_halt_q   <= wrap_halt_d;
`endif
    end
  end

  assign bus.rom_addr  = rom_addr_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_pc    = out_pc_q;
  assign running       = (state_q == S_RUN);
`ifdef FETCH_WRAP_HALT_EN
  assign wrap_halt     = wrap_halt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, multi-cycle corner sequences
// and a randomized run against a stream-level reference model.
module tb_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       halt = 1'b0;
  logic       redirect_valid = 1'b0;
  logic [7:0] redirect_pc = 8'h00;
  logic       running;
`ifdef FETCH_WRAP_HALT_EN
  logic       wrap_halt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  fetch_ctrl_if #(.ADDR_WIDTH(8), .INSTR_WIDTH(16)) bus ();

  fetch_ctrl #(.ADDR_WIDTH(8), .INSTR_WIDTH(16), .RESET_PC(0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
    .running        (running)
`ifdef FETCH_WRAP_HALT_EN
    ,
    .wrap_halt      (wrap_halt)
`endif
  );

  always #5 clk = ~clk;

  // ROM content: each word carries its own address so pc/instr pairing is visible.
  function automatic logic [15:0] rom_f(input logic [7:0] a);
    return {a ^ 8'hC3, a};
  endfunction

  always @(posedge clk) bus.rom_instr <= rom_f(bus.rom_addr);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    start = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_rst_valid"}, bus.out_valid, 0);
    check({tag, "_rst_pc"}, bus.out_pc, 0);
    check({tag, "_rst_instr"}, bus.out_instr, 0);
    check({tag, "_rst_running"}, running, 0);
    check({tag, "_rst_addr"}, bus.rom_addr, 0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         s;
    bit         h;
    bit         r;
    logic [7:0] rpc;
    bit         rdy;
    int         addr;   // -1: address not constrained this cycle
    bit         v;
    logic [7:0] pc;
    bit         run;
  } vec_t;

  function automatic vec_t mk(bit s, bit h, bit r, logic [7:0] rpc, bit rdy,
                              int addr, bit v, logic [7:0] pc, bit run);
    vec_t t;
    t.s = s; t.h = h; t.r = r; t.rpc = rpc; t.rdy = rdy;
    t.addr = addr; t.v = v; t.pc = pc; t.run = run;
    return t;
  endfunction

  localparam int NV = 28;
  vec_t tbl[NV];

  logic       found;
  logic [7:0] exp_pc;
  logic       running_m;
  logic       fire, hold;
  logic [7:0] pv_pc;
  logic [15:0] pv_instr;
  int         n_fire;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(1,0,0,8'h00,1,  0,    0,8'h00,1);
    tbl[1]  = mk(0,0,0,8'h00,1,  1,    1,8'h00,1);
    tbl[2]  = mk(0,0,0,8'h00,1,  2,    1,8'h01,1);
    tbl[3]  = mk(0,0,0,8'h00,1,  3,    1,8'h02,1);
    tbl[4]  = mk(0,0,0,8'h00,1,  4,    1,8'h03,1);
    tbl[5]  = mk(0,0,0,8'h00,1,  5,    1,8'h04,1);
    tbl[6]  = mk(0,0,0,8'h00,1,  6,    1,8'h05,1);
    tbl[7]  = mk(0,0,0,8'h00,0,  6,    1,8'h05,1);
    tbl[8]  = mk(0,0,0,8'h00,0,  6,    1,8'h05,1);
    tbl[9]  = mk(0,0,0,8'h00,0,  6,    1,8'h05,1);
    tbl[10] = mk(0,0,0,8'h00,1,  7,    1,8'h06,1);
    tbl[11] = mk(0,0,0,8'h00,1,  8,    1,8'h07,1);
    tbl[12] = mk(0,0,1,8'h40,1,  'h40, 0,8'h00,1);
    tbl[13] = mk(0,0,0,8'h00,1,  'h41, 1,8'h40,1);
    tbl[14] = mk(0,0,0,8'h00,1,  'h42, 1,8'h41,1);
    tbl[15] = mk(0,0,0,8'h00,0,  'h42, 1,8'h41,1);
    tbl[16] = mk(0,1,0,8'h00,0,  -1,   1,8'h41,0);
    tbl[17] = mk(0,0,0,8'h00,0,  -1,   1,8'h41,0);
    tbl[18] = mk(0,0,0,8'h00,1,  -1,   0,8'h00,0);
    tbl[19] = mk(1,0,0,8'h00,1,  'h42, 0,8'h00,1);
    tbl[20] = mk(0,0,0,8'h00,1,  'h43, 1,8'h42,1);
    tbl[21] = mk(0,0,0,8'h00,1,  'h44, 1,8'h43,1);
    tbl[22] = mk(0,1,0,8'h00,1,  -1,   1,8'h44,0);
    tbl[23] = mk(0,0,0,8'h00,1,  -1,   0,8'h00,0);
    tbl[24] = mk(1,1,0,8'h00,1,  -1,   0,8'h00,0);
    tbl[25] = mk(1,0,0,8'h00,1,  'h45, 0,8'h00,1);
    tbl[26] = mk(1,0,0,8'h00,1,  'h46, 1,8'h45,1);
    tbl[27] = mk(0,0,0,8'h00,1,  'h47, 1,8'h46,1);

    do_reset("init");

    for (int i = 0; i < NV; i++) begin
      start = tbl[i].s; halt = tbl[i].h;
      redirect_valid = tbl[i].r; redirect_pc = tbl[i].rpc;
      bus.out_ready = tbl[i].rdy;
      #1;
      if (tbl[i].addr >= 0)
        check($sformatf("tbl%0d_addr", i), bus.rom_addr, tbl[i].addr);
      step();
      check($sformatf("tbl%0d_valid", i), bus.out_valid, tbl[i].v);
      check($sformatf("tbl%0d_running", i), running, tbl[i].run);
      if (tbl[i].v) begin
        check($sformatf("tbl%0d_pc", i), bus.out_pc, tbl[i].pc);
        check($sformatf("tbl%0d_instr", i), bus.out_instr, rom_f(tbl[i].pc));
      end
    end
    start = 0; halt = 0; redirect_valid = 0;

    // Redirect while pc 3 is on the output.
    do_reset("seqA");
    start = 1; bus.out_ready = 1;
    step();
    start = 0;
    found = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.out_valid && bus.out_pc == 8'h03) begin
        found = 1;
        break;
      end
      step();
    end
    check("seqA_reach_pc3", found, 1);
    redirect_valid = 1; redirect_pc = 8'h40;
    step();
    redirect_valid = 0;
    check("seqA_flush_valid", bus.out_valid, 0);
    step();
    check("seqA_first_valid", bus.out_valid, 1);
    check("seqA_first_pc", bus.out_pc, 8'h40);
    check("seqA_first_instr", bus.out_instr, rom_f(8'h40));
    step();
    check("seqA_second_pc", bus.out_pc, 8'h41);

    // Run across the top of the address space.
    redirect_valid = 1; redirect_pc = 8'hFE;
    step();
    redirect_valid = 0;
    check("seqB_flush_valid", bus.out_valid, 0);
    step();
    check("seqB_pc_fe", bus.out_pc, 8'hFE);
    check("seqB_instr_fe", bus.out_instr, rom_f(8'hFE));
`ifdef FETCH_WRAP_HALT_EN
    check("seqB_wrap_running", running, 0);
    check("seqB_wrap_flag", wrap_halt, 1);
`endif
    step();
    check("seqB_valid_ff", bus.out_valid, 1);
    check("seqB_pc_ff", bus.out_pc, 8'hFF);
`ifdef FETCH_WRAP_HALT_EN
    step();
    check("seqB_halted_valid", bus.out_valid, 0);
    start = 1;
    step();
    start = 0;
    check("seqB_restart_flag", wrap_halt, 0);
    check("seqB_restart_running", running, 1);
    step();
`else
    step();
`endif
    check("seqB_valid_00", bus.out_valid, 1);
    check("seqB_pc_00", bus.out_pc, 8'h00);
    check("seqB_running_00", running, 1);

    // Asynchronous reset in the middle of a cycle.
    step();
    step();
    #3;
    rst_n = 0;
    #1;
    check("seqC_valid", bus.out_valid, 0);
    check("seqC_pc", bus.out_pc, 0);
    check("seqC_instr", bus.out_instr, 0);
    check("seqC_running", running, 0);
    check("seqC_addr", bus.rom_addr, 0);
    @(posedge clk);
    #1;
    rst_n = 1;

    // Randomized run: the delivered stream must be the contiguous PC sequence,
    // restarted at each redirect target, with outputs frozen while stalled.
    running_m = 0;
    exp_pc = 8'h00;
    n_fire = 0;
    for (int c = 0; c < 3000; c++) begin
      bus.out_ready = ($urandom_range(0, 9) < 7);
`ifdef FETCH_WRAP_HALT_EN
      redirect_valid = running_m && ($urandom_range(0, 99) < 5);
      redirect_pc = 8'($urandom_range(0, 63));
`else
      redirect_valid = running_m && ($urandom_range(0, 99) < 3);
      redirect_pc = 8'($urandom_range(0, 255));
`endif
      halt  = !redirect_valid && ($urandom_range(0, 99) < 3);
      start = ($urandom_range(0, 99) < 8);
      #1;
      fire = bus.out_valid && bus.out_ready && !(redirect_valid && running_m);
      hold = bus.out_valid && !bus.out_ready && !(redirect_valid && running_m);
      pv_pc = bus.out_pc;
      pv_instr = bus.out_instr;
      if (fire) begin
        check($sformatf("rand%0d_pc", c), bus.out_pc, exp_pc);
        check($sformatf("rand%0d_instr", c), bus.out_instr, rom_f(exp_pc));
        exp_pc = exp_pc + 8'h01;
        n_fire++;
      end
      step();
      if (hold) begin
        check($sformatf("rand%0d_hold_valid", c), bus.out_valid, 1);
        check($sformatf("rand%0d_hold_pc", c), bus.out_pc, pv_pc);
        check($sformatf("rand%0d_hold_instr", c), bus.out_instr, pv_instr);
      end
      if (redirect_valid && running_m) exp_pc = redirect_pc;
      else if (running_m && halt) running_m = 0;
      else if (!running_m && start && !halt) running_m = 1;
      check($sformatf("rand%0d_running", c), running, running_m);
    end
    start = 0; halt = 0; redirect_valid = 0;
    check("rand_throughput", (n_fire > 600), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
